// File: rtl/risc_control_unit.sv
// Registered instruction decoder: opcode/funct -> ALU, memory, write-back and branch controls, one cycle latency.
// Optional CTRL_ILLEGAL_DETECT_EN adds an illegal_op flag for opcodes outside the decode table.
module risc_control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        stall,
  input  logic        flush,
  output logic [2:0]  alu_op,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        b,
  output logic        br,
  output logic        bz,
  output logic        bnz,
  output logic        bcy,
  output logic        bncy,
  output logic        bs,
  output logic        bns,
  output logic        bv,
  output logic        bnv,
  output logic        Call,
`ifdef CTRL_ILLEGAL_DETECT_EN
  output logic        Ret,
  output logic        illegal_op
`else
  output logic        Ret
`endif
);

  typedef struct packed {
    logic [2:0]  alu_op;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    logic        mem_to_reg;
    logic        reg_write;
    logic [11:0] flow;  // one-hot: bit 0 = b ... bit 11 = Ret, indexed by opcode[3:0]
`ifdef CTRL_ILLEGAL_DETECT_EN
    logic        illegal;
`endif
  } ctrl_t;

  ctrl_t      ctrl_d;
  ctrl_t      ctrl_q;
  logic [5:0] opcode;
  logic [2:0] funct;
  logic       unused_bits;

  assign opcode      = instruction[31:26];
  assign funct       = instruction[2:0];
  assign unused_bits = ^instruction[25:3];

  always_comb begin
    ctrl_d = '0;
    casez (opcode)
      6'h00: begin
        ctrl_d.alu_op    = funct;
        ctrl_d.reg_write = 1'b1;
      end
      6'b001???: begin
        ctrl_d.alu_op    = opcode[2:0];
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
      end
      6'h10: begin
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.mem_read   = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.reg_write  = 1'b1;
      end
      6'h11: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.mem_write = 1'b1;
      end
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
      6'h26, 6'h27, 6'h28, 6'h29, 6'h2A, 6'h2B: begin
        ctrl_d.flow[opcode[3:0]] = 1'b1;
      end
      6'h3F: begin
        ctrl_d = '0;
      end
      default: begin
`ifdef CTRL_ILLEGAL_DETECT_EN
        ctrl_d.illegal = 1'b1;
`endif
      end
    endcase
  end

  // Flush beats stall so a cancelled slot never re-issues a held word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
    end else if (flush) begin
      ctrl_q <= '0;
    end else if (!stall) begin
      ctrl_q <= ctrl_d;
    end
  end

  assign alu_op     = ctrl_q.alu_op;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign alu_src    = ctrl_q.alu_src;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign reg_write  = ctrl_q.reg_write;
  assign b          = ctrl_q.flow[0];
  assign br         = ctrl_q.flow[1];
  assign bz         = ctrl_q.flow[2];
  assign bnz        = ctrl_q.flow[3];
  assign bcy        = ctrl_q.flow[4];
  assign bncy       = ctrl_q.flow[5];
  assign bs         = ctrl_q.flow[6];
  assign bns        = ctrl_q.flow[7];
  assign bv         = ctrl_q.flow[8];
  assign bnv        = ctrl_q.flow[9];
  assign Call       = ctrl_q.flow[10];
  assign Ret        = ctrl_q.flow[11];
`ifdef CTRL_ILLEGAL_DETECT_EN
  assign illegal_op = ctrl_q.illegal;
`endif

endmodule

// File: tb/tb_risc_control_unit.sv
// Scoreboard bench for risc_control_unit: expected control words are queued as stimulus is driven and checked after each edge.
module tb_risc_control_unit;

`ifdef CTRL_ILLEGAL_DETECT_EN
  localparam int W = 21;
`else
  localparam int W = 20;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction = 32'h0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  alu_op;
  logic        mem_read, mem_write, alu_src, mem_to_reg, reg_write;
  logic        b, br, bz, bnz, bcy, bncy, bs, bns, bv, bnv, Call, Ret;
`ifdef CTRL_ILLEGAL_DETECT_EN
  logic        illegal_op;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] model_q = '0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs;
  logic [11:0]  flow_obs;

  always #5 clk = ~clk;

  risc_control_unit dut (
    .clk(clk), .rst(rst), .instruction(instruction), .stall(stall), .flush(flush),
    .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .b(b), .br(br), .bz(bz), .bnz(bnz), .bcy(bcy), .bncy(bncy), .bs(bs), .bns(bns),
    .bv(bv), .bnv(bnv), .Call(Call),
`ifdef CTRL_ILLEGAL_DETECT_EN
    .Ret(Ret), .illegal_op(illegal_op)
`else
    .Ret(Ret)
`endif
  );

  assign flow_obs = {b, br, bz, bnz, bcy, bncy, bs, bns, bv, bnv, Call, Ret};
`ifdef CTRL_ILLEGAL_DETECT_EN
  assign obs = {alu_op, mem_read, mem_write, alu_src, mem_to_reg, reg_write, flow_obs, illegal_op};
`else
  assign obs = {alu_op, mem_read, mem_write, alu_src, mem_to_reg, reg_write, flow_obs};
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference decode, layout {alu_op, mr, mw, asrc, m2r, rw, b..Ret, [illegal]}
  function automatic logic [W-1:0] model(input logic [31:0] ins);
    logic [5:0]  op;
    logic [2:0]  a;
    logic        mr, mw, asrc, m2r, rw, ill;
    logic [11:0] fl;
    op = ins[31:26];
    a = 3'b000; mr = 0; mw = 0; asrc = 0; m2r = 0; rw = 0; ill = 0; fl = '0;
    if (op == 6'd0) begin
      a = ins[2:0]; rw = 1;
    end else if (op >= 6'd8 && op <= 6'd15) begin
      a = op[2:0]; asrc = 1; rw = 1;
    end else if (op == 6'd16) begin
      asrc = 1; mr = 1; m2r = 1; rw = 1;
    end else if (op == 6'd17) begin
      asrc = 1; mw = 1;
    end else if (op >= 6'd32 && op <= 6'd43) begin
      fl = 12'h800 >> (op - 6'd32);
    end else if (op != 6'd63) begin
      ill = 1;
    end
`ifdef CTRL_ILLEGAL_DETECT_EN
    return {a, mr, mw, asrc, m2r, rw, fl, ill};
`else
    if (ill) fl = fl;
    return {a, mr, mw, asrc, m2r, rw, fl};
`endif
  endfunction

  task automatic step(input logic [31:0] ins, input logic stl, input logic fl, input string tag);
    logic [W-1:0] e;
    @(negedge clk);
    instruction = ins;
    stall = stl;
    flush = fl;
    if (fl)        e = '0;
    else if (stl)  e = model_q;
    else           e = model(ins);
    model_q = e;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      check(tag, 32'(obs), 32'(exp_q.pop_front()));
    end
    check({tag, "_flow_onehot0"}, 32'($countones(flow_obs) <= 1), 32'd1);
    check({tag, "_mem_excl"}, 32'(mem_read & mem_write), 32'd0);
    check({tag, "_m2r_rw"}, 32'(mem_to_reg & ~reg_write), 32'd0);
  endtask

  initial begin
    #2;
    check("reset_state", 32'(obs), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    step(32'h0000_0001, 0, 0, "rtype_sub");
    step(32'h2C00_0000, 0, 0, "imm_or");
    step(32'h4400_0000, 0, 0, "st");
    step(32'h4000_0000, 0, 0, "ld");

    // Asynchronous reset mid-cycle with LD applied
    @(negedge clk);
    instruction = 32'h4000_0000;
    #1 rst = 1'b1;
    #1 check("async_rst", 32'(obs), 32'd0);
    model_q = '0;
    @(negedge clk);
    rst = 1'b0;
    step(32'h4000_0000, 0, 0, "ld_after_rst");

    for (int op = 32'h20; op <= 32'h2B; op++)
      step({6'(op), 26'h155_5555}, 0, 0, $sformatf("flow_%0h", op));
    step(32'hE800_0000, 0, 0, "op3a");
    step(32'hFC00_0000, 0, 0, "nop3f");

    for (int f = 0; f < 8; f++)
      step(32'h03FF_FFF8 | 32'(f), 0, 0, $sformatf("rtype_f%0d", f));
    for (int op = 8; op < 16; op++)
      step({6'(op), 26'h3FF_FFFF}, 0, 0, $sformatf("imm_%0h", op));

    step(32'h0000_0000, 0, 0, "add");
    step(32'h8800_0000, 1, 0, "stall_bz");
    step(32'h8800_0000, 1, 0, "stall_bz2");
    step(32'h8800_0000, 0, 0, "bz");
    step(32'hA800_0000, 1, 1, "flush_stall_call");
    step(32'hA800_0000, 0, 0, "call");
    step(32'hA800_0000, 0, 1, "flush_call");

    for (int i = 0; i < 40; i++)
      step($urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), $sformatf("rand_%0d", i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
